sal_arbiter_wrr: RTL and testbench



---
 rtl/sal_arbiter_pkg.sv | 23 ++
 rtl/sal_rr_pick.sv | 33 +++
 rtl/sal_arbiter_wrr.sv | 105 ++++++++++
 tb/tb_sal_arbiter_wrr.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_arbiter_pkg.sv
// Shared types and helpers for the SAL arbiter family.
package sal_arbiter_pkg;

  localparam int unsigned MAX_REQ = 256;
  localparam int unsigned IDX_W   = 8;

  typedef logic [MAX_REQ-1:0] req_mask_t;

  // Pointer width; a 2-requester arbiter still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_bin(input req_mask_t oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx |= IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sal_rr_pick.sv
// Rotating-priority picker: lowest set request at or above ptr, wrapping to 0.
module sal_rr_pick
  import sal_arbiter_pkg::*;
#(
  parameter int unsigned REQ_CNT = 64,
  parameter int unsigned PTR_W   = ptr_width(REQ_CNT)
) (
  input  logic [REQ_CNT-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [REQ_CNT-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [REQ_CNT-1:0]   mask;
  logic [2*REQ_CNT-1:0] dbl;
  logic [2*REQ_CNT-1:0] first;

  always_comb begin
    mask = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
  end

  // Masked copy in the low half wins; the unmasked upper half covers the wrap.
  assign dbl     = {req_i, req_i & mask};
  assign first   = dbl & (-dbl);
  assign gnt_o   = first[REQ_CNT-1:0] | first[2*REQ_CNT-1:REQ_CNT];
  assign idx_o   = PTR_W'(onehot_to_bin(req_mask_t'(gnt_o)));
  assign valid_o = |req_i;

endmodule

// File: rtl/sal_arbiter_wrr.sv
// Weighted round-robin arbiter with payload mux and registered output stage.
module sal_arbiter_wrr
  import sal_arbiter_pkg::*;
#(
  parameter int unsigned REQ_CNT      = 64,
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned WEIGHT_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [REQ_CNT-1:0]                     req_arr_i,
  input  logic [REQ_CNT-1:0][DATA_WIDTH-1:0]     data_arr_i,
  input  logic [REQ_CNT-1:0][WEIGHT_WIDTH-1:0]   weight_arr_i,
  output logic [REQ_CNT-1:0]                     gnt_arr_o,
  output logic                                   req_o,
  output logic [DATA_WIDTH-1:0]                  data_o,
  input  logic                                   gnt_i
);

  localparam int unsigned PTR_W = ptr_width(REQ_CNT);

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic                    owner_valid_q, owner_valid_d;
  logic [WEIGHT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [REQ_CNT-1:0] pick_gnt;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   win_next;
  logic               pick_valid;
  logic               load_en;
  logic               grant;
  logic [WEIGHT_WIDTH-1:0] win_weight;

  sal_rr_pick #(
    .REQ_CNT (REQ_CNT),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i   (req_arr_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (win_idx),
    .valid_o (pick_valid)
  );

  assign load_en    = !req_q || gnt_i;
  assign grant      = load_en && pick_valid;
  assign gnt_arr_o  = (grant && rst_n) ? pick_gnt : '0;
  assign win_next   = (win_idx == PTR_W'(REQ_CNT - 1)) ? '0 : win_idx + 1'b1;
  assign win_weight = weight_arr_i[win_idx];
  assign req_o      = req_q;
  assign data_o     = data_q;

  // owner_valid implies burst_cnt > 0: the burst ends on the grant that consumes its last credit.
  always_comb begin
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    burst_cnt_d   = burst_cnt_q;
    req_d         = req_q;
    data_d        = data_q;
    if (grant) begin
      req_d  = 1'b1;
      data_d = data_arr_i[win_idx];
      if (owner_valid_q && (win_idx == owner_q)) begin
        burst_cnt_d = burst_cnt_q - 1'b1;
        if (burst_cnt_q == WEIGHT_WIDTH'(1)) begin
          ptr_d         = win_next;
          owner_valid_d = 1'b0;
        end else begin
          ptr_d = owner_q;
        end
      end else begin
        owner_d       = win_idx;
        burst_cnt_d   = win_weight;
        owner_valid_d = (win_weight != '0);
        // An aborted burst or a weight-0 winner moves on past the winner.
        ptr_d = (owner_valid_q || (win_weight == '0)) ? win_next : win_idx;
      end
    end else if (load_en) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      burst_cnt_q   <= '0;
      req_q         <= 1'b0;
      data_q        <= '0;
    end else begin
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      burst_cnt_q   <= burst_cnt_d;
      req_q         <= req_d;
      data_q        <= data_d;
    end
  end

endmodule

// File: tb/tb_sal_arbiter_wrr.sv
// Directed self-checking bench for sal_arbiter_wrr (default 64 requesters).
module tb_sal_arbiter_wrr;

  localparam int N  = 64;
  localparam int DW = 12;
  localparam int WW = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [N-1:0]          req;
  logic [N-1:0][DW-1:0]  data;
  logic [N-1:0][WW-1:0]  weight;
  logic [N-1:0]          gnt_arr;
  logic                  req_o;
  logic [DW-1:0]         data_o;
  logic                  gnt_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sal_arbiter_wrr #(
    .REQ_CNT      (N),
    .DATA_WIDTH   (DW),
    .WEIGHT_WIDTH (WW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_arr_i    (req),
    .data_arr_i   (data),
    .weight_arr_i (weight),
    .gnt_arr_o    (gnt_arr),
    .req_o        (req_o),
    .data_o       (data_o),
    .gnt_i        (gnt_i)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    weight = '0;
    gnt_i  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req = '1;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (gnt_arr !== '0) begin
      miscompares++; $display("FAIL reset_gnt got %h want 0", gnt_arr);
    end
    vectors++;
    if (req_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_req_o got %b want 0", req_o);
    end
    vectors++;
    if (data_o !== '0) begin
      miscompares++; $display("FAIL reset_data_o got %h want 0", data_o);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    req = '1;
    #1;
    vectors++;
    if (gnt_arr !== 64'h1 || req_o !== 1'b0) begin
      miscompares++; $display("FAIL rr_first got gnt=%h req_o=%b want gnt=1 req_o=0", gnt_arr, req_o);
    end
    for (int k = 1; k <= N; k++) begin
      next_cycle();
      req[k-1] = 1'b0;
      #1;
      exp_g = '0;
      if (k < N) exp_g[k] = 1'b1;
      vectors++;
      if (gnt_arr !== exp_g) begin
        miscompares++; $display("FAIL rr_gnt k=%0d got %h want %h", k, gnt_arr, exp_g);
      end
      vectors++;
      if (req_o !== 1'b1 || data_o !== DW'(12'h100 + k - 1)) begin
        miscompares++;
        $display("FAIL rr_out k=%0d got req_o=%b data=%h want 1/%h", k, req_o, data_o,
                 DW'(12'h100 + k - 1));
      end
    end
    next_cycle();
    #1;
    vectors++;
    if (req_o !== 1'b0 || data_o !== 12'h13f) begin
      miscompares++; $display("FAIL rr_idle got req_o=%b data=%h want 0/13f", req_o, data_o);
    end
  endtask

  task automatic test_weighted();
    int seq [7] = '{0, 0, 0, 1, 2, 2, 3};
    logic [N-1:0] exp_g;
    do_reset();
    weight[0] = 4'd2;
    weight[2] = 4'd1;
    req = 64'hf;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) next_cycle();
      #1;
      exp_g = '0;
      exp_g[seq[c % 7]] = 1'b1;
      vectors++;
      if (gnt_arr !== exp_g) begin
        miscompares++; $display("FAIL wrr_gnt c=%0d got %h want %h", c, gnt_arr, exp_g);
      end
      if (c > 0) begin
        vectors++;
        if (data_o !== DW'(12'h100 + seq[(c - 1) % 7])) begin
          miscompares++;
          $display("FAIL wrr_data c=%0d got %h want %h", c, data_o,
                   DW'(12'h100 + seq[(c - 1) % 7]));
        end
      end
    end
  endtask

  task automatic test_burst_single();
    int exp_ptr [10] = '{5, 5, 5, 6, 5, 5, 5, 6, 5, 5};
    do_reset();
    weight[5] = 4'd3;
    req[5] = 1'b1;
    for (int g = 0; g < 10; g++) begin
      #1;
      vectors++;
      if (gnt_arr !== (64'h1 << 5)) begin
        miscompares++; $display("FAIL burst_gnt g=%0d got %h want bit 5", g, gnt_arr);
      end
      next_cycle();
      vectors++;
      if (int'(dut.ptr_q) != exp_ptr[g]) begin
        miscompares++; $display("FAIL burst_ptr g=%0d got %0d want %0d", g, dut.ptr_q, exp_ptr[g]);
      end
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    gnt_i = 1'b0;
    req = 64'he;
    #1;
    vectors++;
    if (gnt_arr !== 64'h2) begin
      miscompares++; $display("FAIL bp_first got %h want 2", gnt_arr);
    end
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      req[1] = 1'b0;
      #1;
      vectors++;
      if (gnt_arr !== '0 || req_o !== 1'b1 || data_o !== 12'h101) begin
        miscompares++;
        $display("FAIL bp_hold c=%0d got gnt=%h req_o=%b data=%h want 0/1/101", c, gnt_arr, req_o,
                 data_o);
      end
    end
    gnt_i = 1'b1;
    #1;
    vectors++;
    if (gnt_arr !== 64'h4) begin
      miscompares++; $display("FAIL bp_release got %h want 4", gnt_arr);
    end
    next_cycle();
    req[2] = 1'b0;
    #1;
    vectors++;
    if (data_o !== 12'h102 || gnt_arr !== 64'h8) begin
      miscompares++; $display("FAIL bp_next got data=%h gnt=%h want 102/8", data_o, gnt_arr);
    end
  endtask

  task automatic test_abort();
    do_reset();
    weight[2] = 4'd3;
    req[2] = 1'b1;
    req[7] = 1'b1;
    #1;
    vectors++;
    if (gnt_arr !== 64'h4) begin
      miscompares++; $display("FAIL abort_first got %h want 4", gnt_arr);
    end
    next_cycle();
    req[2] = 1'b0;
    #1;
    vectors++;
    if (gnt_arr !== 64'h80 || dut.ptr_q !== 6'd2) begin
      miscompares++; $display("FAIL abort_gnt got gnt=%h ptr=%0d want 80/2", gnt_arr, dut.ptr_q);
    end
    next_cycle();
    req[7] = 1'b0;
    #1;
    vectors++;
    if (dut.ptr_q !== 6'd8 || data_o !== 12'h107 || gnt_arr !== '0) begin
      miscompares++;
      $display("FAIL abort_ptr got ptr=%0d data=%h gnt=%h want 8/107/0", dut.ptr_q, data_o, gnt_arr);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    weight[10] = 4'd3;
    req[10] = 1'b1;
    #1;
    vectors++;
    if (gnt_arr !== (64'h1 << 10)) begin
      miscompares++; $display("FAIL rmb_first got %h want bit 10", gnt_arr);
    end
    next_cycle();
    req[3] = 1'b1;
    #1;
    vectors++;
    if (gnt_arr !== (64'h1 << 10)) begin
      miscompares++; $display("FAIL rmb_owner got %h want bit 10", gnt_arr);
    end
    next_cycle();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (gnt_arr !== '0 || req_o !== 1'b0 || data_o !== '0) begin
      miscompares++;
      $display("FAIL rmb_reset got gnt=%h req_o=%b data=%h want 0/0/0", gnt_arr, req_o, data_o);
    end
    next_cycle();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (gnt_arr !== 64'h8) begin
      miscompares++; $display("FAIL rmb_after got %h want 8", gnt_arr);
    end
    next_cycle();
    #1;
    vectors++;
    if (data_o !== 12'h103 || req_o !== 1'b1) begin
      miscompares++; $display("FAIL rmb_data got data=%h req_o=%b want 103/1", data_o, req_o);
    end
  endtask

  initial begin
    req    = '0;
    weight = '0;
    gnt_i  = 1'b1;
    for (int i = 0; i < N; i++) data[i] = DW'(12'h100 + i);
    test_reset();
    test_round_robin();
    test_weighted();
    test_burst_single();
    test_backpressure();
    test_abort();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
